dma_arg_loader: RTL and testbench
=================================

// Module: dma_arg_loader
// PURPOSE
//  Generalised operand fetcher for the ECDSA command engine. It DMA-reads an
//  argument pointer table, then dereferences each pointer into an operand
//  register bank for the arithmetic cores (montgomery, EC add/mult).
//  The table may span several DMA beats. It reports per-argument valid flags,
//  done/error status and a reason code.
// PARAMETERS
//  DATA_W      381   DMA payload width, also the operand width
//  ADDR_W      32    DMA / pointer address width
//  MAX_ARGC    8     operand slots in the bank
//  ARGC_W      4     width of argc; must be >= $clog2(MAX_ARGC+1)
//  BEAT_BYTES  128   address stride between consecutive table beats (1024-bit AXI beat)
//  TIMEOUT_CYC 4096  watchdog limit in cycles (used only with ARGLD_TIMEOUT_EN)
// PORTS
//  clk            in   1               clock
//  resetn         in   1               synchronous, active-low reset
//  start          in   1               level command; sampled in IDLE
//  table_base     in   ADDR_W          byte address of the pointer table
//  argc           in   ARGC_W          number of operands to fetch
//  busy           out  1               high whenever state is not IDLE, DONE or ERR
//  done           out  1               high in DONE
//  err            out  1               high in ERR
//  err_code       out  2               0 none, 1 bad argc, 2 dma_error, 3 timeout
//  operands       out  MAX_ARGC*DATA_W slot i occupies [i*DATA_W +: DATA_W]
//  valid_mask     out  MAX_ARGC        bit i set once slot i is loaded
//  dma_rx_address out  ADDR_W          DMA read address
//  dma_rx_start   out  1               one-cycle DMA read request pulse
//  dma_rx_data    in   DATA_W          DMA read data, valid on dma_done
//  dma_done       in   1               DMA transfer completion pulse
//  dma_idle       in   1               DMA engine idle
//  dma_error      in   1               DMA fault
// BEHAVIOUR
//  Reset: every output reads 0, state = IDLE. Reset mid-transfer aborts to
//   IDLE; any late dma_done is ignored.
//  PPB = DATA_W/32 pointers per beat (11 at the default). Pointer j sits at
//   beat j/PPB, bits [DATA_W-1-32*(j%PPB) -: 32], ordered MSB first.
//  IDLE: on start, clear valid_mask and err_code. If argc==0 or argc>MAX_ARGC,
//   go to ERR with code 1 on the next cycle. Otherwise go to TBL_REQ with
//   beat=0 and idx=0.
//  TBL_REQ: hold until dma_idle, then drive dma_rx_address =
//   table_base + beat*BEAT_BYTES and pulse dma_rx_start for 1 cycle; go to TBL_WAIT.
//  TBL_WAIT: on dma_done, latch the beat's pointers into the ptr buffer and go
//   to ARG_REQ. Only ceil(argc/PPB) beats are read; each beat is read after
//   the previous beat's pointers have been consumed.
//  ARG_REQ: same handshake as TBL_REQ; dma_rx_address = ptr[idx]; go to ARG_WAIT.
//  ARG_WAIT: on dma_done, write slot idx, set valid_mask[idx], idx++.
//   Next state: DONE if idx==argc-1; TBL_REQ if the next pointer lies in an
//   unread beat; otherwise ARG_REQ.
//  dma_error in any *_WAIT state goes to ERR with code 2 and takes priority
//   over a simultaneous dma_done, which is discarded.
//  DONE / ERR: hold outputs, operands and valid_mask. Return to IDLE when
//   start==0. done and err are never high together.
//  Latency (no errors, DMA responds in L cycles): about
//   (ceil(argc/PPB)+argc)*(L+2)+1 cycles from start to done.
//  Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.
// CONFIGURATION
//  ARGLD_TIMEOUT_EN defined: a watchdog counter clears on every *_REQ entry
//   and counts in *_REQ and *_WAIT. When it reaches TIMEOUT_CYC, go to ERR
//   with code 3 and issue no further dma_rx_start.
//  ARGLD_TIMEOUT_EN undefined: no counter; a stalled DMA hangs in *_WAIT;
//   err_code 3 is never produced.
// STRUCTURE
//  Shared package ecdsa_pkg: state enum, ERR_* code constants, default
//   BEAT_BYTES.
//  One sub-module, arg_ptr_unpack: combinational extraction of pointer j from
//   the latched beat. Kept separate so the top stays FSM + datapath.
// TESTING
//  1. argc=3, ptrs 0x100/0x200/0x300 hold A/B/M -> 4 rx starts; slots 0..2
//     equal A/B/M; valid_mask=0b111; done=1; err=0.
//  2. argc=0, then argc=9 -> ERR, err_code=1, zero dma_rx_start pulses.
//  3. MAX_ARGC=16, argc=12 -> second table read at table_base+128, issued
//     after the 11th operand; slot 11 correct.
//  4. dma_error and dma_done together on the 2nd operand -> ERR code 2;
//     valid_mask=0b001; slot 1 unchanged.
//  5. resetn low during ARG_WAIT, then a late dma_done -> outputs 0, state
//     IDLE, no slot written.
//  6. With ARGLD_TIMEOUT_EN, TIMEOUT_CYC=64, dma_done withheld -> err_code=3
//     after 64 cycles; start=0 -> IDLE.

Source files
------------

// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA command engine: operand-loader FSM states,
// error reason codes, pointer width and the default table beat stride.
package ecdsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TBL_REQ  = 3'd1,
        ST_TBL_WAIT = 3'd2,
        ST_ARG_REQ  = 3'd3,
        ST_ARG_WAIT = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } argld_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ARGC    = 2'd1;
    localparam logic [1:0] ERR_DMA     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int PTR_W          = 32;
    localparam int DEF_BEAT_BYTES = 128;

    function automatic logic is_busy_state(input argld_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/arg_ptr_unpack.sv
// Selects pointer <slot> from a latched table beat; pointers are packed MSB first.
module arg_ptr_unpack
    import ecdsa_pkg::*;
#(
    parameter int PPB    = 11,
    parameter int SLOT_W = 4
) (
    input  logic [PPB*PTR_W-1:0] i_beat,
    input  logic [SLOT_W-1:0]    i_slot,
    output logic [PTR_W-1:0]     o_ptr
);

    logic [PTR_W-1:0] w_ptrs [2**SLOT_W];

    for (genvar k = 0; k < 2**SLOT_W; k++) begin : g_ptr
        if (k < PPB) begin : g_used
            assign w_ptrs[k] = i_beat[PPB*PTR_W-1-PTR_W*k -: PTR_W];
        end else begin : g_pad
            assign w_ptrs[k] = {PTR_W{1'b0}};
        end
    end

    assign o_ptr = w_ptrs[i_slot];

endmodule

// File: rtl/dma_arg_loader.sv
// ECDSA operand fetcher: DMA-reads a pointer table, then each operand it points to.
// Optional watchdog: define ARGLD_TIMEOUT_EN (adds the TIMEOUT_CYC parameter).
module dma_arg_loader
    import ecdsa_pkg::*;
#(
    parameter int DATA_W      = 381,
    parameter int ADDR_W      = 32,
    parameter int MAX_ARGC    = 8,
    parameter int ARGC_W      = 4,
`ifdef ARGLD_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 4096,
`endif
    parameter int BEAT_BYTES  = DEF_BEAT_BYTES
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_start,
    input  logic [ADDR_W-1:0]          i_table_base,
    input  logic [ARGC_W-1:0]          i_argc,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [1:0]                 o_err_code,
    output logic [MAX_ARGC*DATA_W-1:0] o_operands,
    output logic [MAX_ARGC-1:0]        o_valid_mask,
    output logic [ADDR_W-1:0]          o_dma_rx_address,
    output logic                       o_dma_rx_start,
    input  logic [DATA_W-1:0]          i_dma_rx_data,
    input  logic                       i_dma_done,
    input  logic                       i_dma_idle,
    input  logic                       i_dma_error
);

    localparam int PPB    = DATA_W / PTR_W;
    localparam int SLOT_W = (PPB > 1) ? $clog2(PPB) : 1;

    argld_state_t               r_state, w_next;
    logic                       w_issue, w_err_set, w_timeout;
    logic [1:0]                 w_err_val;
    logic                       w_argc_bad, w_last, w_beat_end;
    logic [ARGC_W-1:0]          r_argc, r_idx, r_beat;
    logic [SLOT_W-1:0]          r_slot;
    logic [ADDR_W-1:0]          r_base, r_rx_addr, w_tbl_addr;
    logic [PPB*PTR_W-1:0]       r_ptr_beat;
    logic [PTR_W-1:0]           w_ptr;
    logic [MAX_ARGC*DATA_W-1:0] r_operands;
    logic [MAX_ARGC-1:0]        r_valid_mask;
    logic [1:0]                 r_err_code;
    logic                       r_busy, r_done, r_err, r_rx_start;

    assign w_argc_bad = (i_argc == {ARGC_W{1'b0}}) || (i_argc > ARGC_W'(MAX_ARGC));
    assign w_tbl_addr = r_base + ADDR_W'(r_beat) * ADDR_W'(BEAT_BYTES);
    assign w_last     = (r_idx == r_argc - ARGC_W'(1'b1));
    assign w_beat_end = (r_slot == SLOT_W'(PPB - 1));

    arg_ptr_unpack #(
        .PPB    (PPB),
        .SLOT_W (SLOT_W)
    ) u_unpack (
        .i_beat (r_ptr_beat),
        .i_slot (r_slot),
        .o_ptr  (w_ptr)
    );

`ifdef ARGLD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wdog;

    // Watchdog restarts on every request entry and runs while a handshake is open.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdog <= {WD_W{1'b0}};
        end else if ((w_next == ST_TBL_REQ || w_next == ST_ARG_REQ) && (w_next != r_state)) begin
            r_wdog <= {WD_W{1'b0}};
        end else if (is_busy_state(r_state)) begin
            r_wdog <= r_wdog + WD_W'(1'b1);
        end else begin
            r_wdog <= r_wdog;
        end
    end

    assign w_timeout = is_busy_state(r_state) && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a DMA fault outranks a simultaneous completion.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_err_set = 1'b0;
        w_err_val = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_argc_bad) begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_ARGC;
                end else if (i_start) begin
                    w_next = ST_TBL_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_TBL_REQ, ST_ARG_REQ: begin
                if (w_timeout) begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_TIMEOUT;
                end else if (i_dma_idle) begin
                    w_issue = 1'b1;
                    w_next  = (r_state == ST_TBL_REQ) ? ST_TBL_WAIT : ST_ARG_WAIT;
                end else begin
                    w_next = r_state;
                end
            end
            ST_TBL_WAIT, ST_ARG_WAIT: begin
                if (i_dma_error) begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_DMA;
                end else if (w_timeout) begin
                    w_next    = ST_ERR;
                    w_err_set = 1'b1;
                    w_err_val = ERR_TIMEOUT;
                end else if (!i_dma_done) begin
                    w_next = r_state;
                end else if (r_state == ST_TBL_WAIT) begin
                    w_next = ST_ARG_REQ;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end else if (w_beat_end) begin
                    w_next = ST_TBL_REQ;
                end else begin
                    w_next = ST_ARG_REQ;
                end
            end
            ST_DONE, ST_ERR: begin
                if (!i_start) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = r_state;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Registered status, request port, pointer buffer and operand bank.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_rx_start   <= 1'b0;
            r_rx_addr    <= {ADDR_W{1'b0}};
            r_argc       <= {ARGC_W{1'b0}};
            r_idx        <= {ARGC_W{1'b0}};
            r_beat       <= {ARGC_W{1'b0}};
            r_slot       <= {SLOT_W{1'b0}};
            r_base       <= {ADDR_W{1'b0}};
            r_ptr_beat   <= {(PPB*PTR_W){1'b0}};
            r_operands   <= {(MAX_ARGC*DATA_W){1'b0}};
            r_valid_mask <= {MAX_ARGC{1'b0}};
        end else begin
            r_busy     <= is_busy_state(w_next);
            r_done     <= (w_next == ST_DONE);
            r_err      <= (w_next == ST_ERR);
            r_rx_start <= w_issue;
            if (w_issue) begin
                r_rx_addr <= (r_state == ST_TBL_REQ) ? w_tbl_addr : ADDR_W'(w_ptr);
            end
            if (w_err_set) begin
                r_err_code <= w_err_val;
            end else if (r_state == ST_IDLE && i_start) begin
                r_err_code <= ERR_NONE;
            end
            if (r_state == ST_IDLE && i_start) begin
                r_valid_mask <= {MAX_ARGC{1'b0}};
                r_argc       <= i_argc;
                r_base       <= i_table_base;
                r_idx        <= {ARGC_W{1'b0}};
                r_beat       <= {ARGC_W{1'b0}};
                r_slot       <= {SLOT_W{1'b0}};
            end
            if (r_state == ST_TBL_WAIT && w_next == ST_ARG_REQ) begin
                r_ptr_beat <= i_dma_rx_data[DATA_W-1 -: PPB*PTR_W];
            end
            if (r_state == ST_ARG_WAIT && i_dma_done && w_next != ST_ERR) begin
                for (int s = 0; s < MAX_ARGC; s++) begin
                    if (r_idx == ARGC_W'(s)) begin
                        r_operands[s*DATA_W +: DATA_W] <= i_dma_rx_data;
                        r_valid_mask[s]                <= 1'b1;
                    end
                end
                r_idx  <= r_idx + ARGC_W'(1'b1);
                r_slot <= w_beat_end ? {SLOT_W{1'b0}} : r_slot + SLOT_W'(1'b1);
                if (w_beat_end) begin
                    r_beat <= r_beat + ARGC_W'(1'b1);
                end
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_err_code       = r_err_code;
    assign o_operands       = r_operands;
    assign o_valid_mask     = r_valid_mask;
    assign o_dma_rx_address = r_rx_addr;
    assign o_dma_rx_start   = r_rx_start;

endmodule

// File: tb/tb_dma_arg_loader.sv
// Directed bench for dma_arg_loader: two instances (MAX_ARGC 8 and 16) sharing
// one behavioural DMA responder; the watchdog case runs when ARGLD_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_dma_arg_loader;

    localparam int DW = 381;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic           start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
    logic [31:0]    tbase   = 32'h0;
    logic [3:0]     argc_a  = 4'd0;
    logic [4:0]     argc_b  = 5'd0;

    logic           a_busy, a_done, a_err, a_rxs;
    logic [1:0]     a_code;
    logic [8*DW-1:0] a_ops;
    logic [7:0]     a_vm;
    logic [31:0]    a_addr;
    logic           b_busy, b_done, b_err, b_rxs;
    logic [1:0]     b_code;
    logic [16*DW-1:0] b_ops;
    logic [15:0]    b_vm;
    logic [31:0]    b_addr;

    logic [DW-1:0]  rx_data   = '0;
    logic           dma_done  = 1'b0, dma_error = 1'b0, pend = 1'b0;
    logic [31:0]    pend_addr = 32'h0;
    int             lat       = 0;
    int             rx_cnt    = 0;
    int             err_at    = -1;
    logic           hold_done = 1'b0;
    logic [31:0]    req_log [$];
    logic [DW-1:0]  mem [logic [31:0]];

    wire            w_rxs    = sel ? b_rxs  : a_rxs;
    wire [31:0]     w_addr   = sel ? b_addr : a_addr;
    wire            dma_idle = ~pend;

    dma_arg_loader
`ifdef ARGLD_TIMEOUT_EN
        #(.TIMEOUT_CYC(64))
`endif
    u_dut_a (
        .clk(clk), .resetn(resetn), .i_start(start_a), .i_table_base(tbase), .i_argc(argc_a),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_err_code(a_code),
        .o_operands(a_ops), .o_valid_mask(a_vm), .o_dma_rx_address(a_addr), .o_dma_rx_start(a_rxs),
        .i_dma_rx_data(rx_data), .i_dma_done(dma_done), .i_dma_idle(dma_idle), .i_dma_error(dma_error)
    );

    dma_arg_loader #(.MAX_ARGC(16), .ARGC_W(5)) u_dut_b (
        .clk(clk), .resetn(resetn), .i_start(start_b), .i_table_base(tbase), .i_argc(argc_b),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_err_code(b_code),
        .o_operands(b_ops), .o_valid_mask(b_vm), .o_dma_rx_address(b_addr), .o_dma_rx_start(b_rxs),
        .i_dma_rx_data(rx_data), .i_dma_done(dma_done), .i_dma_idle(dma_idle), .i_dma_error(dma_error)
    );

    // DMA model: answers each request after a fixed latency, unaffected by DUT reset.
    always @(posedge clk) begin
        dma_done  <= 1'b0;
        dma_error <= 1'b0;
        if (w_rxs) begin
            pend      <= 1'b1;
            pend_addr <= w_addr;
            lat       <= 3;
            rx_cnt    <= rx_cnt + 1;
            req_log.push_back(w_addr);
        end else if (pend && !hold_done) begin
            if (lat == 0) begin
                dma_done  <= 1'b1;
                dma_error <= (rx_cnt == err_at);
                rx_data   <= mem.exists(pend_addr) ? mem[pend_addr] : '0;
                pend      <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input bit use_b, input int budget, input string tag);
        int n = 0;
        while (!(use_b ? (b_done || b_err) : (a_done || a_err)) && n < budget) begin
            step(1);
            n++;
        end
        check(tag, use_b ? (b_done || b_err) : (a_done || a_err), 1'b1);
    endtask

    function automatic logic [DW-1:0] opval(input logic [31:0] a);
        logic [383:0] w;
        w = {12{a ^ 32'hC3A5_0F17}};
        return w[DW-1:0];
    endfunction

    logic [DW-1:0] beat;
    logic [DW-1:0] op_a, op_b, op_m;
    int            c0;

    initial begin
        op_a = opval(32'h100);
        op_b = opval(32'h200);
        op_m = opval(32'h300);
        mem[32'h100] = op_a;
        mem[32'h200] = op_b;
        mem[32'h300] = op_m;
        beat = '0;
        beat[380 -: 32] = 32'h100;
        beat[348 -: 32] = 32'h200;
        beat[316 -: 32] = 32'h300;
        mem[32'h1000] = beat;

        // reset state
        step(3);
        check("reset_a_ctrl", {a_busy, a_done, a_err, a_code, a_vm, a_addr, a_rxs}, 512'h0);
        check("reset_a_ops", a_ops, 512'h0);
        check("reset_b_ctrl", {b_busy, b_done, b_err, b_code, b_vm, b_addr, b_rxs}, 512'h0);
        resetn = 1'b1;
        step(1);

        // 1: three operands from one table beat
        tbase = 32'h1000; argc_a = 4'd3; c0 = rx_cnt;
        start_a = 1'b1;
        step(1);
        check("t1_busy", a_busy, 1'b1);
        wait_end(1'b0, 200, "t1_bound");
        check("t1_done_err", {a_done, a_err, a_code}, 4'b1000);
        check("t1_mask", a_vm, 8'b0000_0111);
        check("t1_slot0", a_ops[0*DW +: DW], op_a);
        check("t1_slot1", a_ops[1*DW +: DW], op_b);
        check("t1_slot2", a_ops[2*DW +: DW], op_m);
        check("t1_slot3", a_ops[3*DW +: DW], 512'h0);
        check("t1_rx_starts", rx_cnt - c0, 4);
        check("t1_last_addr", a_addr, 32'h300);
        start_a = 1'b0;
        step(2);
        check("t1_idle", {a_busy, a_done, a_err}, 3'b000);

        // 2: argc out of range
        argc_a = 4'd0; c0 = rx_cnt;
        start_a = 1'b1;
        wait_end(1'b0, 10, "t2a_bound");
        check("t2a_err", {a_done, a_err, a_code}, 4'b0101);
        check("t2a_mask_cleared", a_vm, 8'h00);
        check("t2a_slot0_held", a_ops[0*DW +: DW], op_a);
        start_a = 1'b0;
        step(2);
        check("t2a_idle", a_err, 1'b0);
        argc_a = 4'd9;
        start_a = 1'b1;
        wait_end(1'b0, 10, "t2b_bound");
        check("t2b_err", {a_done, a_err, a_code}, 4'b0101);
        check("t2_rx_starts", rx_cnt - c0, 0);
        start_a = 1'b0;
        step(2);

        // 3: twelve operands spanning two table beats
        beat = '0;
        for (int k = 0; k < 11; k++) beat[380-32*k -: 32] = 32'h8000 + 32'(k) * 32'h40;
        mem[32'h4000] = beat;
        beat = '0;
        beat[380 -: 32] = 32'h82C0;
        mem[32'h4080] = beat;
        for (int k = 0; k < 12; k++) mem[32'h8000 + 32'(k) * 32'h40] = opval(32'h8000 + 32'(k) * 32'h40);
        sel = 1'b1; tbase = 32'h4000; argc_b = 5'd12; c0 = rx_cnt;
        start_b = 1'b1;
        wait_end(1'b1, 600, "t3_bound");
        check("t3_done_err", {b_done, b_err, b_code}, 4'b1000);
        check("t3_mask", b_vm, 16'h0FFF);
        check("t3_rx_starts", rx_cnt - c0, 14);
        check("t3_op10_addr", req_log[c0+11], 32'h8280);
        check("t3_tbl1_addr", req_log[c0+12], 32'h4080);
        check("t3_slot11", b_ops[11*DW +: DW], opval(32'h82C0));
        check("t3_slot10", b_ops[10*DW +: DW], opval(32'h8280));
        start_b = 1'b0;
        step(2);
        sel = 1'b0;

        // 4: dma_error together with dma_done on the second operand
        mem[32'h200] = opval(32'hDEAD_0200);
        tbase = 32'h1000; argc_a = 4'd3; c0 = rx_cnt; err_at = c0 + 3;
        start_a = 1'b1;
        wait_end(1'b0, 200, "t4_bound");
        check("t4_err", {a_done, a_err, a_code}, 4'b0110);
        check("t4_mask", a_vm, 8'b0000_0001);
        check("t4_slot1_kept", a_ops[1*DW +: DW], op_b);
        check("t4_slot0", a_ops[0*DW +: DW], op_a);
        check("t4_rx_starts", rx_cnt - c0, 3);
        start_a = 1'b0;
        err_at = -1;
        step(2);

        // 5: reset during ARG_WAIT, then a late completion
        mem[32'h100] = opval(32'hBEEF_0100);
        c0 = rx_cnt;
        start_a = 1'b1;
        for (int n = 0; n < 100 && rx_cnt < c0 + 2; n++) step(1);
        hold_done = 1'b1;
        check("t5_in_arg_wait", {a_busy, rx_cnt - c0}, {1'b1, 32'd2});
        step(1);
        resetn = 1'b0; start_a = 1'b0;
        step(2);
        resetn = 1'b1;
        hold_done = 1'b0;
        step(10);
        check("t5_ctrl", {a_busy, a_done, a_err, a_code, a_vm, a_rxs}, 512'h0);
        check("t5_ops", a_ops, 512'h0);
        check("t5_rx_starts", rx_cnt - c0, 2);

`ifdef ARGLD_TIMEOUT_EN
        // 6: withheld completion trips the watchdog
        tbase = 32'h1000; argc_a = 4'd1; c0 = rx_cnt;
        hold_done = 1'b1;
        start_a = 1'b1;
        step(40);
        check("t6_still_waiting", {a_busy, a_err}, 2'b10);
        step(40);
        check("t6_timeout", {a_done, a_err, a_code}, 4'b0111);
        check("t6_rx_starts", rx_cnt - c0, 1);
        start_a = 1'b0;
        step(2);
        check("t6_idle", {a_busy, a_err}, 2'b00);
        hold_done = 1'b0;
        step(10);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
